// File: rtl/gpi_pkg.sv
// Shared constants for the GPI input path (debounce stage and GPI peripheral).
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
package gpi_pkg;

  // Channel count shared by the debounce stage and the GPI peripheral pin input.
  localparam int GPI_WIDTH               = 8;
  // Default debounce tick: 1 kHz from a 100 MHz clk.
  localparam int DB_CLK_DIV_DEFAULT      = 100000;
  // Default number of consecutive ticks a new level must survive.
  localparam int DB_STABLE_TICKS_DEFAULT = 10;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchroniser, tick-qualified stability counter, edge pulses.
// Latency: 2 + (STABLE_TICKS-1)*tick_period+1 .. 2 + STABLE_TICKS*tick_period clk cycles.
// Backpressure: none; free-running, an output change is never held off.
//
// Ports: clk, reset (async, active-high), raw (asynchronous pin), tick (shared strobe),
//        db (debounced level), rise / fall (one-cycle pulses on db 0->1 / 1->0).
module debounce_channel
  import gpi_pkg::*;
#(
  parameter int STABLE_TICKS = DB_STABLE_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int              CW       = cnt_width(STABLE_TICKS + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // Plain two-flop chain, nothing between the flops, so the first stage has a
  // full cycle to resolve metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // The counter only advances on ticks while the synchronised level disagrees
  // with db; any cycle of agreement throws away the progress made so far.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_q2 == db) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          db   <= sync_q2;
          cnt  <= '0;
          rise <= sync_q2;
          fall <= ~sync_q2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/gpi_debounce.sv
// Conditions raw GPI pins: synchronise, debounce per channel, emit rise/fall pulses.
// Latency: 2 + [(STABLE_TICKS-1)*CLK_DIV+1 .. STABLE_TICKS*CLK_DIV] clk cycles raw -> gpi_db.
// Backpressure: none; purely streaming, outputs update unconditionally.
//
// Ports: clk, reset (async, active-high), gpi_raw[WIDTH] (asynchronous pins),
//        gpi_db[WIDTH] (debounced, registered; drives the GPI peripheral gpi input),
//        rise_pulse / fall_pulse[WIDTH] (one-cycle edge strobes), tick (prescaler strobe).
module gpi_debounce
  import gpi_pkg::*;
#(
  parameter int WIDTH        = GPI_WIDTH,
  parameter int CLK_DIV      = DB_CLK_DIV_DEFAULT,
  parameter int STABLE_TICKS = DB_STABLE_TICKS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpi_raw,
  output logic [WIDTH-1:0] gpi_db,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             tick
);

  localparam int            PW       = cnt_width(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] pre_cnt;

  // One prescaler shared by every channel. tick is registered from the
  // terminal count, so it fires the cycle after pre_cnt == CLK_DIV-1; with
  // CLK_DIV == 1 the counter sits at 0 and tick stays high every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (pre_cnt == PRE_LAST);
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (gpi_raw[i]),
      .tick  (tick),
      .db    (gpi_db[i]),
      .rise  (rise_pulse[i]),
      .fall  (fall_pulse[i])
    );
  end

endmodule

// File: doc/gpi_debounce.md
Name: gpi_debounce

Overview:
- Input-conditioning stage placed directly upstream of the GPI bus peripheral; its gpi_db output drives that peripheral's 8-bit gpi pin input.
- Synchronises raw switch/button pins to clk and debounces each channel with a shared tick prescaler.
- Also emits one-cycle rise/fall pulses per channel for edge-triggered consumers (interrupt logic, counters).

Parameters:
- WIDTH, 8, number of independent input channels.
- CLK_DIV, 100000, clk cycles per debounce tick (1 kHz at 100 MHz); legal range >= 1, where 1 means a tick every cycle.
- STABLE_TICKS, 10, consecutive ticks a changed level must persist before it is accepted; legal range >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- gpi_raw  input  WIDTH  asynchronous raw pin levels.
- gpi_db  output  WIDTH  debounced, registered levels; feeds the GPI peripheral gpi input.
- rise_pulse  output  WIDTH  one-cycle pulse when gpi_db[i] goes 0->1.
- fall_pulse  output  WIDTH  one-cycle pulse when gpi_db[i] goes 1->0.
- tick  output  1  prescaler strobe, exported for the bench and for other slow logic.

Behaviour:
- Reset (async, active-high) clears all of the following: sync flops, prescaler, per-channel counters, gpi_db, rise_pulse, fall_pulse, tick.
- Synchroniser: 2-FF chain per bit; sync[i] = gpi_raw[i] delayed 2 clk edges. No logic between the two flops.
- Prescaler: counter 0..CLK_DIV-1, wraps to 0. tick is registered and high for exactly one cycle when the count equals CLK_DIV-1. Width is $clog2(CLK_DIV), minimum 1 bit.
- Per-channel counter cnt[i], width $clog2(STABLE_TICKS+1), updated as follows:
  - sync[i] == gpi_db[i]: cnt[i] <= 0 on any cycle, so any return to the old level restarts qualification.
  - sync[i] != gpi_db[i] and tick and cnt[i] == STABLE_TICKS-1: gpi_db[i] <= sync[i], cnt[i] <= 0, and the matching pulse is set.
  - sync[i] != gpi_db[i] and tick otherwise: cnt[i] <= cnt[i]+1.
  - sync[i] != gpi_db[i] with no tick: hold.
- Pulses: rise_pulse[i] and fall_pulse[i] are registered on the same edge as the gpi_db[i] update. They are high for exactly 1 cycle and cleared on the next cycle. They are never both high for the same bit.
- Latency: raw change to gpi_db change is 2 + [(STABLE_TICKS-1)*CLK_DIV+1 .. STABLE_TICKS*CLK_DIV] clk cycles, depending on tick phase.
- Glitch rejection: a level change lasting fewer than STABLE_TICKS-1 ticks (fewer than (STABLE_TICKS-1)*CLK_DIV+1 cycles) never reaches gpi_db.
- Channels are fully independent. Simultaneous qualification on several bits produces simultaneous pulses.
- Reset mid-count: all qualification progress is lost. A raw level of 1 held through reset re-qualifies from gpi_db=0 and produces a rise_pulse after the full latency.
- No bus interface; the block is purely streaming.

Decomposition:
- Shared package gpi_pkg holds:
  - GPI_WIDTH = 8
  - DB_CLK_DIV_DEFAULT = 100000
  - DB_STABLE_TICKS_DEFAULT = 10
- The GPI peripheral and the top level share GPI_WIDTH.
- Sub-module debounce_channel (sync chain, cnt, gpi_db bit, pulses; inputs clk, reset, raw, tick) is instantiated WIDTH times in a generate loop.
- The prescaler lives in the top level, one instance shared by all channels.

Test Plan (all scenarios use CLK_DIV=4, STABLE_TICKS=3, so latency = 11..14 cycles from the raw edge):
- Clean press: gpi_raw=8'h01 held -> gpi_db=8'h01 within 11..14 cycles; rise_pulse=8'h01 for exactly 1 cycle, coincident with the gpi_db change; tick period = 4 cycles.
- Glitch: gpi_raw[1] high for 6 cycles then low -> gpi_db stays 8'h00; no pulses.
- Bounce: gpi_raw[2] toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one rise_pulse[2], 11..14 cycles after the final edge; gpi_db[2]=1.
- Release: from gpi_db=8'hFF, drive gpi_raw=8'h00 -> gpi_db=8'h00 within 11..14 cycles; fall_pulse=8'hFF for 1 cycle, all bits together; rise_pulse stays 0.
- Reset mid-qualification: gpi_raw=8'h80, assert reset at cycle 8 for 2 cycles -> outputs 0 immediately (async); gpi_db[7] rises 11..14 cycles after reset deassert, with one rise_pulse.
- Mixed channels: bit0 rises, bit3 falls on the same cycle, bit5 glitches for 2 cycles -> rise_pulse=8'h01 and fall_pulse=8'h08 on the same cycle; bit5 unchanged.
